// File: rtl/conv_output_tm.sv
// Time-multiplexed multi-filter convolution output stage: PAR MAC lanes sweep OUT_CH filters over NGRP passes.
// Optional build macro CONV_OUT_RELU_EN clamps negative lane results to zero at write.
`timescale 1ns/1ps
module conv_output_tm #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int IN_CH  = 3,
  parameter int OUT_CH = 8,
  parameter int PAR    = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [IN_CH*9*DATA_W-1:0]        window_in,
  input  logic [OUT_CH*IN_CH*9*DATA_W-1:0] weight_bank,
  output logic                             busy,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [OUT_CH*ACC_W-1:0]          acc_out
);

  localparam int NGRP   = OUT_CH / PAR;
  localparam int TAPS   = IN_CH * 9;
  localparam int WIN_W  = TAPS * DATA_W;
  localparam int BANK_W = OUT_CH * WIN_W;
  localparam int FULL_W = 2 * DATA_W + $clog2(TAPS);
  localparam int GRP_W  = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(NGRP - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                    r_state;
  logic [GRP_W-1:0]          r_grp;
  logic [WIN_W-1:0]          r_win;
  logic [OUT_CH*ACC_W-1:0]   r_acc;
  logic                      r_busy;
  logic                      r_out_valid;

  logic                      w_accept;
  logic [31:0]               w_grp_base;
  logic [PAR*ACC_W-1:0]      w_lane;

  // Full-precision dot product, then size-cast to ACC_W (sign-extends or wraps).
  function automatic logic [ACC_W-1:0] dot_filter(input logic [WIN_W-1:0]  win,
                                                  input logic [BANK_W-1:0] bank,
                                                  input logic [31:0]       f);
    logic signed [FULL_W-1:0]   sum;
    logic signed [DATA_W-1:0]   a;
    logic signed [DATA_W-1:0]   b;
    logic signed [2*DATA_W-1:0] p;
    logic signed [ACC_W-1:0]    res;
    sum = '0;
    for (int unsigned c = 0; c < IN_CH; c++) begin
      for (int unsigned k = 0; k < 9; k++) begin
        a   = win[(c*9 + k)*DATA_W +: DATA_W];
        b   = bank[((f*IN_CH + c)*9 + k)*DATA_W +: DATA_W];
        p   = a * b;
        sum = sum + FULL_W'(p);
      end
    end
    res = ACC_W'(sum);
`ifdef CONV_OUT_RELU_EN
    if (res[ACC_W-1]) res = '0;
`endif
    return res;
  endfunction

  assign in_ready   = !rst && ((r_state == S_IDLE) || ((r_state == S_DONE) && out_ready));
  assign w_accept   = in_valid && in_ready;
  assign w_grp_base = 32'(r_grp) * 32'(PAR);

  always_comb begin
    w_lane = '0;
    for (int unsigned l = 0; l < PAR; l++)
      w_lane[l*ACC_W +: ACC_W] = dot_filter(r_win, weight_bank, w_grp_base + l);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_grp       <= '0;
      r_win       <= '0;
      r_acc       <= '0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_win   <= window_in;
            r_grp   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          for (int unsigned l = 0; l < PAR; l++)
            r_acc[(w_grp_base + l)*ACC_W +: ACC_W] <= w_lane[l*ACC_W +: ACC_W];
          if (r_grp == GRP_LAST) begin
            r_grp       <= '0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_grp <= r_grp + GRP_W'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (in_valid) begin
              r_win   <= window_in;
              r_grp   <= '0;
              r_state <= S_RUN;
            end else begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign acc_out   = r_acc;

endmodule

// File: tb/tb_conv_output_tm.sv
// Directed/random bench for conv_output_tm (PAR=2 and PAR=8 instances) against an integer reference model.
`timescale 1ns/1ps
module tb_conv_output_tm;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 32;
  localparam int IN_CH  = 3;
  localparam int OUT_CH = 8;
  localparam int PAR    = 2;
  localparam int NGRP   = OUT_CH / PAR;
  localparam int WIN_W  = IN_CH * 9 * DATA_W;
  localparam int BANK_W = OUT_CH * WIN_W;
  localparam int OUT_W  = OUT_CH * ACC_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              in_valid, in_ready, busy, out_valid, out_ready;
  logic              in_valid8, in_ready8, busy8, out_valid8, out_ready8;
  logic [WIN_W-1:0]  window_in;
  logic [BANK_W-1:0] weight_bank;
  logic [OUT_W-1:0]  acc_out, acc_out8;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int win_a [IN_CH][9];
  int wt_a  [OUT_CH][IN_CH][9];

  always @(posedge clk) cyc <= cyc + 1;

  conv_output_tm #(.DATA_W(DATA_W), .ACC_W(ACC_W), .IN_CH(IN_CH), .OUT_CH(OUT_CH), .PAR(PAR)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .window_in(window_in), .weight_bank(weight_bank), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out));

  conv_output_tm #(.DATA_W(DATA_W), .ACC_W(ACC_W), .IN_CH(IN_CH), .OUT_CH(OUT_CH), .PAR(OUT_CH)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .window_in(window_in), .weight_bank(weight_bank), .busy(busy8),
    .out_valid(out_valid8), .out_ready(out_ready8), .acc_out(acc_out8));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chkv(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [OUT_W-1:0] model();
    logic [OUT_W-1:0]        r;
    longint                  s;
    logic signed [ACC_W-1:0] t;
    r = '0;
    for (int f = 0; f < OUT_CH; f++) begin
      s = 0;
      for (int c = 0; c < IN_CH; c++)
        for (int k = 0; k < 9; k++)
          s += longint'(win_a[c][k]) * longint'(wt_a[f][c][k]);
      t = s[ACC_W-1:0];
`ifdef CONV_OUT_RELU_EN
      if (t < 0) t = 0;
`endif
      r[f*ACC_W +: ACC_W] = t;
    end
    return r;
  endfunction

  task automatic pack();
    for (int c = 0; c < IN_CH; c++)
      for (int k = 0; k < 9; k++)
        window_in[(c*9 + k)*DATA_W +: DATA_W] = DATA_W'(win_a[c][k]);
    for (int f = 0; f < OUT_CH; f++)
      for (int c = 0; c < IN_CH; c++)
        for (int k = 0; k < 9; k++)
          weight_bank[((f*IN_CH + c)*9 + k)*DATA_W +: DATA_W] = DATA_W'(wt_a[f][c][k]);
  endtask

  task automatic win_const(input int v);
    for (int c = 0; c < IN_CH; c++) for (int k = 0; k < 9; k++) win_a[c][k] = v;
  endtask

  task automatic wt_const(input int v);
    for (int f = 0; f < OUT_CH; f++)
      for (int c = 0; c < IN_CH; c++) for (int k = 0; k < 9; k++) wt_a[f][c][k] = v;
  endtask

  task automatic wt_by_filter();
    for (int f = 0; f < OUT_CH; f++)
      for (int c = 0; c < IN_CH; c++) for (int k = 0; k < 9; k++) wt_a[f][c][k] = f;
  endtask

  task automatic rand_win();
    for (int c = 0; c < IN_CH; c++)
      for (int k = 0; k < 9; k++) win_a[c][k] = int'($urandom_range(255)) - 128;
  endtask

  task automatic rand_wt();
    for (int f = 0; f < OUT_CH; f++)
      for (int c = 0; c < IN_CH; c++)
        for (int k = 0; k < 9; k++) wt_a[f][c][k] = int'($urandom_range(255)) - 128;
  endtask

  // Presents a window on the PAR=2 instance; e0 is the edge that completed the handshake.
  task automatic accept(input string tag, output int e0);
    e0 = -1;
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (in_ready) begin
        step();
        e0 = cyc;
        break;
      end
      step();
    end
    in_valid = 1'b0;
    chk1({tag, "_accept"}, e0 >= 0, 1'b1);
  endtask

  task automatic wait_done(input string tag, output int e1);
    e1 = -1;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) begin
        e1 = cyc;
        break;
      end
      step();
    end
    chk1({tag, "_out_valid"}, out_valid, 1'b1);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    #1;
    chk1({tag, "_in_ready_when_out_ready"}, in_ready, 1'b1);
    step();
    out_ready = 1'b0;
    chk1({tag, "_drained"}, out_valid, 1'b0);
  endtask

  initial begin
    int e0, e1, seen, got;
    logic [OUT_W-1:0] exp1, exp2;
    logic [WIN_W-1:0] wv [4];
    logic [OUT_W-1:0] ex [4];
    int ae [4];

    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b0;
    window_in = '0; weight_bank = '0;
    step(); step();
    chk1("rst_in_ready_low", in_ready, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chkv("rst_acc", acc_out, '0);
    rst = 1'b0;
    #1;
    chk1("post_rst_in_ready", in_ready, 1'b1);

    // Ramp filters: acc[f] = 27*f, latency check
    win_const(1); wt_by_filter(); pack();
    accept("ramp", e0);
    chk1("ramp_busy", busy, 1'b1);
    chk1("ramp_in_ready_run", in_ready, 1'b0);
    wait_done("ramp", e1);
    chki("ramp_latency_edges", e1 - e0, NGRP);
    chkv("ramp_acc", acc_out, model());
    chki("ramp_f7", int'(acc_out[7*ACC_W +: ACC_W]), 189);
    chk1("ramp_in_ready_done", in_ready, 1'b0);
    consume("ramp");
    chk1("ramp_idle_busy", busy, 1'b0);

    // Extreme operands
    win_const(-128); wt_const(-128); pack();
    accept("neg", e0);
    wait_done("neg", e1);
    chki("neg_f0", int'(acc_out[0 +: ACC_W]), 442368);
    chkv("neg_acc", acc_out, model());
    consume("neg");
    wt_const(127); pack();
    accept("mix", e0);
    wait_done("mix", e1);
`ifdef CONV_OUT_RELU_EN
    chki("mix_f3", int'(acc_out[3*ACC_W +: ACC_W]), 0);
`else
    chki("mix_f3", int'(acc_out[3*ACC_W +: ACC_W]), -438912);
`endif
    chkv("mix_acc", acc_out, model());
    consume("mix");

    // Backpressure hold with a second window waiting
    rand_win(); rand_wt(); pack();
    accept("hold", e0);
    wait_done("hold", e1);
    exp1 = model();
    rand_win(); pack();
    exp2 = model();
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk1("hold_out_valid", out_valid, 1'b1);
      chkv("hold_acc_stable", acc_out, exp1);
      chk1("hold_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    chk1("hold_release_ready", in_ready, 1'b1);
    step();
    e0 = cyc;
    out_ready = 1'b0; in_valid = 1'b0;
    chk1("hold_second_run", busy, 1'b1);
    chk1("hold_out_dropped", out_valid, 1'b0);
    wait_done("hold2", e1);
    chki("hold2_latency_edges", e1 - e0, NGRP);
    chkv("hold2_acc", acc_out, exp2);
    consume("hold2");

    // Back-to-back stream
    rand_wt();
    for (int i = 0; i < 4; i++) begin
      rand_win(); pack();
      wv[i] = window_in;
      ex[i] = model();
    end
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      window_in = wv[i];
      got = 0;
      for (int t = 0; t < 40 && got == 0; t++) begin
        if (in_ready) begin
          if (i > 0) begin
            chk1("b2b_valid_at_accept", out_valid, 1'b1);
            chkv("b2b_acc", acc_out, ex[i-1]);
          end
          step();
          ae[i] = cyc;
          got = 1;
        end else begin
          step();
        end
      end
      chki("b2b_accepted", got, 1);
      if (i > 0) chki("b2b_interval", ae[i] - ae[i-1], NGRP + 1);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    wait_done("b2b_last", e1);
    chkv("b2b_last_acc", acc_out, ex[3]);
    consume("b2b_last");

    // Reset in the second RUN cycle aborts the window
    rand_win(); pack();
    accept("abort", e0);
    step();
    rst = 1'b1;
    #1;
    chk1("abort_rst_in_ready", in_ready, 1'b0);
    step();
    rst = 1'b0;
    #1;
    chk1("abort_out_valid", out_valid, 1'b0);
    chkv("abort_acc", acc_out, '0);
    chk1("abort_in_ready", in_ready, 1'b1);
    chk1("abort_busy", busy, 1'b0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) seen++;
    end
    chki("abort_no_output", seen, 0);
    rand_win(); pack();
    accept("after_abort", e0);
    wait_done("after_abort", e1);
    chkv("after_abort_acc", acc_out, model());
    consume("after_abort");

    // Single-pass instance, ramp stimulus
    win_const(1); wt_by_filter(); pack();
    in_valid8 = 1'b1;
    #1;
    chk1("p8_in_ready", in_ready8, 1'b1);
    step();
    e0 = cyc;
    in_valid8 = 1'b0;
    e1 = -1;
    for (int i = 0; i < 20; i++) begin
      if (out_valid8) begin
        e1 = cyc;
        break;
      end
      step();
    end
    chk1("p8_out_valid", out_valid8, 1'b1);
    chki("p8_latency_edges", e1 - e0, 1);
    chkv("p8_acc", acc_out8, model());
    out_ready8 = 1'b1;
    step();
    out_ready8 = 1'b0;
    chk1("p8_drained", out_valid8, 1'b0);
    chk1("p8_idle_busy", busy8, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
